// File: rtl/csa_job_scheduler_if.sv
// rtl/csa_job_scheduler_if.sv - channel, FIFO, core and output handshake bundle for csa_job_scheduler
interface csa_job_scheduler_if #(
  parameter int NUM_CH = 4
);
  logic              enable;
  logic [NUM_CH-1:0] ch_req;
  logic [NUM_CH-1:0] ch_grant;
  logic              csa_in_r_ready;
  logic              csa_in_ren;
  logic              core_start;
  logic [7:0]        core_round;
  logic              core_done;
  logic              core_abort;
  logic              out_wready;
  logic              out_wen;
  logic              job_done;
  logic [2:0]        job_ch;
  logic              err_timeout;

  modport master (
    input  enable, ch_req, csa_in_r_ready, core_done, out_wready,
    output ch_grant, csa_in_ren, core_start, core_round, core_abort,
           out_wen, job_done, job_ch, err_timeout
  );

  modport slave (
    output enable, ch_req, csa_in_r_ready, core_done, out_wready,
    input  ch_grant, csa_in_ren, core_start, core_round, core_abort,
           out_wen, job_done, job_ch, err_timeout
  );
endinterface

// File: rtl/csa_job_scheduler.sv
// rtl/csa_job_scheduler.sv - round-robin job sequencer for one shared CSA core
// Optional per-round watchdog enabled by defining CSA_SCHED_WATCHDOG_EN.
module csa_job_scheduler #(
  parameter int NUM_CH         = 4,
  parameter int CSA_CALC_TIMES = 5,
  parameter int WDT_CYCLES     = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  csa_job_scheduler_if.master  bus
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_ARB        = 3'd1;
  localparam logic [2:0] S_FETCH      = 3'd2;
  localparam logic [2:0] S_CALC_START = 3'd3;
  localparam logic [2:0] S_CALC_WAIT  = 3'd4;
  localparam logic [2:0] S_DRAIN      = 3'd5;

  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
`ifdef CSA_SCHED_WATCHDOG_EN
  localparam bit WDT_EN = 1'b1;
`else
  localparam bit WDT_EN = 1'b0;
`endif

  logic [2:0]        state_q, state_d;
  logic [2:0]        rr_ptr_q, rr_ptr_d;
  logic [2:0]        job_ch_q, job_ch_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic [7:0]        round_q, round_d;
  logic [WDT_W-1:0]  wdt_q, wdt_d;
  logic              err_q, err_d;

  logic              arb_found;
  logic [2:0]        arb_idx;
  logic [3:0]        arb_best;
  logic [3:0]        arb_dist;
  logic              fire_ren, fire_start, fire_wen, fire_abort;
  logic              last_round;

  // Pick the requester closest to rr_ptr going upward, distance taken modulo NUM_CH.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = 3'd0;
    arb_best  = 4'hF;
    arb_dist  = 4'd0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (4'(j) >= {1'b0, rr_ptr_q}) arb_dist = 4'(j) - {1'b0, rr_ptr_q};
      else                           arb_dist = 4'(j) + 4'(NUM_CH) - {1'b0, rr_ptr_q};
      if (bus.ch_req[j] && (arb_dist < arb_best)) begin
        arb_best  = arb_dist;
        arb_idx   = 3'(j);
        arb_found = 1'b1;
      end
    end
  end

  assign last_round = (round_q == 8'(CSA_CALC_TIMES - 1));

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    job_ch_d   = job_ch_q;
    grant_d    = grant_q;
    round_d    = round_q;
    wdt_d      = wdt_q;
    err_d      = err_q;
    fire_ren   = 1'b0;
    fire_start = 1'b0;
    fire_wen   = 1'b0;
    fire_abort = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.enable && (|bus.ch_req)) state_d = S_ARB;
      end
      S_ARB: begin
        if (arb_found) begin
          grant_d  = NUM_CH'(1) << arb_idx;
          job_ch_d = arb_idx;
          rr_ptr_d = (arb_idx == 3'(NUM_CH - 1)) ? 3'd0 : arb_idx + 3'd1;
          state_d  = S_FETCH;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_FETCH: begin
        if (bus.csa_in_r_ready) begin
          fire_ren = 1'b1;
          state_d  = S_CALC_START;
        end
      end
      S_CALC_START: begin
        fire_start = 1'b1;
        wdt_d      = '0;
        state_d    = S_CALC_WAIT;
      end
      S_CALC_WAIT: begin
        if (bus.core_done) begin
          if (last_round) begin
            state_d = S_DRAIN;
          end else begin
            round_d = round_q + 8'd1;
            state_d = S_CALC_START;
          end
        end else if (WDT_EN) begin
          // The WDT_CYCLES-th cycle spent waiting on one round kills the job.
          if (wdt_q == WDT_W'(WDT_CYCLES - 1)) begin
            fire_abort = 1'b1;
            err_d      = 1'b1;
            grant_d    = '0;
            job_ch_d   = 3'd0;
            round_d    = 8'd0;
            state_d    = S_IDLE;
          end else begin
            wdt_d = wdt_q + WDT_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (bus.out_wready) begin
          fire_wen = 1'b1;
          grant_d  = '0;
          job_ch_d = 3'd0;
          round_d  = 8'd0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= 3'd0;
      job_ch_q <= 3'd0;
      grant_q  <= '0;
      round_q  <= 8'd0;
      wdt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      job_ch_q <= job_ch_d;
      grant_q  <= grant_d;
      round_q  <= round_d;
      wdt_q    <= wdt_d;
      err_q    <= err_d;
    end
  end

  assign bus.ch_grant    = grant_q;
  assign bus.job_ch      = job_ch_q;
  assign bus.csa_in_ren  = fire_ren;
  assign bus.core_start  = fire_start;
  assign bus.core_round  = round_q;
  assign bus.core_abort  = fire_abort;
  assign bus.out_wen     = fire_wen;
  assign bus.job_done    = fire_wen;
  assign bus.err_timeout = err_q;

endmodule
